// File: rtl/instr_cache_controller.sv
// L1 instruction cache control: set decode, fetch hit,
// and replacement gating while a branch that missed is unresolved.
module instr_cache_controller (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [5:0]  set_i,
   input  logic [63:0] miss_array_i,
   input  logic [1:0]  pc_src_reg_i,
   input  logic [1:0]  branch_op_e_i,
   output logic [63:0] active_array_o,
   output logic        instr_hit_f_o,
   output logic        ic_repl_permit_o
);

   typedef enum logic {
      READY   = 1'b0,
      BR_PEND = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic miss_f;
   logic br_e;
   logic mispred;
   logic unused_bits;

   assign miss_f  = miss_array_i[set_i];
   assign br_e    = branch_op_e_i[0];
   assign mispred = pc_src_reg_i[1];

   // Only the conditional-branch flag and misprediction flag matter here.
   assign unused_bits = ^{pc_src_reg_i[0], branch_op_e_i[1]};

   // One-hot set enable and hit flag, purely from the fetch index.
   always_comb begin
      active_array_o        = '0;
      active_array_o[set_i] = 1'b1;
      instr_hit_f_o         = ~miss_f;
   end

   // State register; reset forces READY immediately.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= READY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and Mealy permit: block a fill under an unresolved
   // branch, then release it only if the branch was predicted right.
   always_comb begin
      state_d          = READY;
      ic_repl_permit_o = 1'b1;
      unique case (state_q)
         READY: begin
            ic_repl_permit_o = ~(br_e & miss_f);
            if (br_e & miss_f) begin
               state_d = BR_PEND;
            end
         end
         BR_PEND: begin
            ic_repl_permit_o = ~mispred;
            state_d          = READY;
         end
         default: begin
            state_d          = READY;
            ic_repl_permit_o = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_cache_controller.sv
// Scoreboard bench for instr_cache_controller: stimulus pushes
// expected outputs, a monitor pops and compares them.
module tb_instr_cache_controller;

   logic        clk_i;
   logic        reset_i;
   logic [5:0]  set_i;
   logic [63:0] miss_array_i;
   logic [1:0]  pc_src_reg_i;
   logic [1:0]  branch_op_e_i;
   logic [63:0] active_array_o;
   logic        instr_hit_f_o;
   logic        ic_repl_permit_o;

   typedef struct {
      string       name;
      logic [63:0] active;
      logic        hit;
      logic        permit;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [63:0] PAT  = 64'h0123456789ABCDEF;
   localparam logic [63:0] ALL  = {64{1'b1}};
   localparam logic [63:0] NONE = 64'h0;

   instr_cache_controller dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .set_i            (set_i),
      .miss_array_i     (miss_array_i),
      .pc_src_reg_i     (pc_src_reg_i),
      .branch_op_e_i    (branch_op_e_i),
      .active_array_o   (active_array_o),
      .instr_hit_f_o    (instr_hit_f_o),
      .ic_repl_permit_o (ic_repl_permit_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Drive one vector and queue what the outputs must be.
   task automatic apply(input string nm, input logic [1:0] op,
                        input logic [63:0] miss, input logic [5:0] s,
                        input logic [1:0] pc, input logic exp_permit);
      exp_t e;
      logic [63:0] oh;
      branch_op_e_i = op;
      miss_array_i  = miss;
      set_i         = s;
      pc_src_reg_i  = pc;
      oh            = 64'd1 << s;
      e.name        = nm;
      e.active      = oh;
      e.hit         = ~miss[s];
      e.permit      = exp_permit;
      exp_q.push_back(e);
   endtask

   // Monitor: sample 1 time unit after a vector is queued.
   initial begin
      exp_t e;
      forever begin
         wait (exp_q.size() != 0);
         #1;
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (active_array_o !== e.active) begin
               n_bad++;
               $display("FAIL %s active: got %h want %h",
                        e.name, active_array_o, e.active);
            end
            n_cmp++;
            if (instr_hit_f_o !== e.hit) begin
               n_bad++;
               $display("FAIL %s hit: got %b want %b",
                        e.name, instr_hit_f_o, e.hit);
            end
            n_cmp++;
            if (ic_repl_permit_o !== e.permit) begin
               n_bad++;
               $display("FAIL %s permit: got %b want %b",
                        e.name, ic_repl_permit_o, e.permit);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i       = 1'b1;
      set_i         = '0;
      miss_array_i  = '0;
      pc_src_reg_i  = '0;
      branch_op_e_i = 2'b00;

      // Decode sweep under reset; permit follows READY equation.
      for (int s = 0; s < 64; s++) begin
         apply("decode", 2'b00, PAT, 6'(s), 2'b00, 1'b1);
         #2;
      end
      // Branch miss under reset: READY equation blocks.
      apply("rst_brmiss", 2'b01, ALL, 6'd9, 2'b10, 1'b0);
      #2;

      @(negedge clk_i);
      reset_i = 1'b0;
      apply("nb_hit", 2'b00, NONE, 6'd5, 2'b00, 1'b1);
      @(negedge clk_i);
      apply("nb_miss", 2'b00, ALL, 6'd5, 2'b00, 1'b1);
      @(negedge clk_i);
      apply("br_hit", 2'b01, NONE, 6'd40, 2'b10, 1'b1);
      @(negedge clk_i);
      // Correct-branch miss: blocked now, BR_PEND next.
      apply("br_miss", 2'b01, ALL, 6'd63, 2'b00, 1'b0);
      @(negedge clk_i);
      // BR_PEND, correct prediction; branch+miss does not extend.
      apply("pend_ok", 2'b01, ALL, 6'd63, 2'b01, 1'b1);
      @(negedge clk_i);
      // Back in READY: same inputs block again and re-enter.
      apply("reenter", 2'b01, ALL, 6'd0, 2'b00, 1'b0);
      @(negedge clk_i);
      // BR_PEND with misprediction blocks even on a plain hit.
      apply("pend_mis", 2'b00, NONE, 6'd1, 2'b10, 1'b0);
      #2;
      apply("pend_mis2", 2'b01, ALL, 6'd1, 2'b11, 1'b0);
      @(negedge clk_i);
      // READY ignores pc_src.
      apply("rdy_pc0", 2'b00, NONE, 6'd2, 2'b00, 1'b1);
      #2;
      apply("rdy_pc1", 2'b00, NONE, 6'd2, 2'b10, 1'b1);
      @(negedge clk_i);
      // Async reset in the middle of BR_PEND.
      apply("ar_enter", 2'b01, ALL, 6'd33, 2'b00, 1'b0);
      @(negedge clk_i);
      apply("ar_pend", 2'b00, PAT, 6'd33, 2'b10, 1'b0);
      #2;
      reset_i = 1'b1;
      apply("ar_reset", 2'b00, PAT, 6'd33, 2'b10, 1'b1);
      @(negedge clk_i);
      reset_i = 1'b0;
      apply("ar_after", 2'b00, NONE, 6'd17, 2'b10, 1'b1);
      @(negedge clk_i);

      repeat (5) @(negedge clk_i);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
